frame_buf_alt: RTL and testbench
================================

Name: frame_buf_alt

Overview:
- Single-clock frame buffer: a RAM of DEPTH words of DATA_WIDTH bits.
- Independent write and read address counters auto-increment on active-low enables, so an upstream producer streams pixel words in and a downstream consumer streams them out in the same order.
- Sits between pixel source and display/consumer logic; no external addressing.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out.
- ADDR_WIDTH, 10, width of the internal address counters.
- DEPTH, 1024, words per frame; must satisfy DEPTH <= 2**ADDR_WIDTH and DEPTH >= 2.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en_in  input  1  active-low write enable.
- rd_en_in  input  1  active-low read enable.
- data_in  input  DATA_WIDTH  word to store.
- data_out  output  DATA_WIDTH  registered read data.
- wr_frame_done  output  1  one-cycle pulse when the last word of a frame (address DEPTH-1) is written.
- rd_frame_done  output  1  one-cycle pulse when the last word of a frame is read.

Behaviour:
- Reset (reset=1 at a rising edge):
  - wr_addr=0, rd_addr=0, data_out=0, wr_frame_done=0, rd_frame_done=0.
  - RAM contents are not cleared; enables are ignored while reset=1.
- Write (wr_en_in=0):
  - mem[wr_addr] <= data_in.
  - wr_addr <= (wr_addr==DEPTH-1) ? 0 : wr_addr+1.
  - wr_frame_done <= 1 exactly when wr_addr==DEPTH-1; else 0.
- Read (rd_en_in=0):
  - data_out <= mem[rd_addr]; one-cycle latency, valid the edge after the enabled edge.
  - rd_addr wraps at DEPTH-1 the same way as wr_addr.
  - rd_frame_done pulses on the wrap, as for writes.
- rd_en_in=1: data_out holds its last value; rd_addr holds.
- wr_en_in=1: RAM and wr_addr unchanged.
- Simultaneous read and write:
  - Different addresses: both complete in the same cycle.
  - Same address: read-before-write, so data_out gets the old contents.
- No full/empty protection:
  - Writing past the read pointer overwrites unread data.
  - Reading past the write pointer returns stale or uninitialised RAM contents.
  - Neither condition is flagged.
- Reset asserted mid-stream: counters return to 0 on that edge; in-flight read data is discarded (data_out=0).
- The RAM must infer as a simple dual-port block RAM; no asynchronous read.

Optional Feature:
- Macro: FRAME_BUF_ALT_PINGPONG_EN.
- Defined:
  - RAM is 2*DEPTH words in two banks; a 1-bit wr_bank register (reset 0) selects the write bank.
  - Reads always use bank ~wr_bank.
  - wr_bank toggles on the edge where the write address wraps (the same edge wr_frame_done is asserted), and rd_addr is forced to 0 on that edge.
  - A complete frame is therefore always readable while the next one is written.
  - Same-address collision cannot occur.
- Not defined: single bank exactly as in Behaviour; no wr_bank register.

Test Plan:
- Reset behaviour: hold reset=1 for 2 cycles with data_in=0x1 and wr_en_in=rd_en_in=1 -> data_out=0 and both done flags 0; RAM and counters untouched.
- Sequential write then read:
  - After reset, wr_en_in=0 for 5 cycles with data_in=0x2,0x3,0x4,0x5,0x6, then wr_en_in=1.
  - Then rd_en_in=0 for 5 cycles -> data_out=0x2,0x3,0x4,0x5,0x6 on consecutive edges, each one cycle after its enabled edge.
  - data_out holds 0x6 after rd_en_in returns to 1.
- Wrap and done flags (DEPTH=4):
  - Write 0xA0..0xA4 (5 words) -> wr_frame_done pulses once, on the 4th write; 0xA4 overwrites address 0.
  - Then read 4 words -> 0xA4,0xA1,0xA2,0xA3; rd_frame_done pulses on the 4th read.
- Same-address collision:
  - Write 0x11 to address 0, then reset pointers via reset.
  - Then drive wr_en_in=0 and rd_en_in=0 together with data_in=0x22 -> data_out=0x11 next cycle.
  - A subsequent read of address 0 returns 0x22.
- Mid-stream reset: reset=1 during a read burst -> data_out=0 the next cycle; after release, the first read returns mem[0].
- Ping-pong (macro defined, DEPTH=4):
  - Write frame 0x1..0x4 -> bank toggles.
  - Read 4 words while writing 0x5..0x8 -> reads return 0x1..0x4 unaffected by the concurrent writes.

Source files
------------

// File: rtl/frame_buf_alt.sv
// rtl/frame_buf_alt.sv - streaming frame buffer with auto-incrementing write/read counters
// Optional build macro: FRAME_BUF_ALT_PINGPONG_EN (two banks, reader works on the completed frame)
module frame_buf_alt #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic                  rd_en_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done
);

`ifdef FRAME_BUF_ALT_PINGPONG_EN
    localparam int MEM_WORDS = 2 * DEPTH;
    localparam int MA_W      = ADDR_WIDTH + 1;
`else
    localparam int MEM_WORDS = DEPTH;
    localparam int MA_W      = ADDR_WIDTH;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Storage is never reset so it maps onto a plain simple dual-port block RAM
    logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rd_done_q, rd_done_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [MA_W-1:0]       wr_mem_addr;
    logic [MA_W-1:0]       rd_mem_addr;

    logic wr_fire, rd_fire;
    logic wr_wrap, rd_wrap;

    assign wr_fire = ~wr_en_in;
    assign rd_fire = ~rd_en_in;
    assign wr_wrap = (wr_addr_q == LAST_ADDR);
    assign rd_wrap = (rd_addr_q == LAST_ADDR);

`ifdef FRAME_BUF_ALT_PINGPONG_EN
    logic wr_bank_q, wr_bank_d;

    // Write bank flips when a frame completes; the reader always owns the other bank
    always_comb begin
        wr_bank_d = wr_bank_q;
        if (wr_fire && wr_wrap) begin
            wr_bank_d = ~wr_bank_q;
        end
    end

    // Bank register, cleared to bank 0 on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
        end
    end

    // Bank offset is an add rather than a concatenation so DEPTH need not be a power of two
    assign wr_mem_addr = MA_W'(wr_addr_q) + (wr_bank_q ? MA_W'(DEPTH) : '0);
    assign rd_mem_addr = MA_W'(rd_addr_q) + (wr_bank_q ? '0 : MA_W'(DEPTH));
`else
    assign wr_mem_addr = wr_addr_q;
    assign rd_mem_addr = rd_addr_q;
`endif

    // Next-state for both address counters and the frame-done pulses
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        if (wr_fire) begin
            wr_addr_d = wr_wrap ? '0 : wr_addr_q + ADDR_WIDTH'(1);
            wr_done_d = wr_wrap;
        end
        if (rd_fire) begin
            rd_addr_d = rd_wrap ? '0 : rd_addr_q + ADDR_WIDTH'(1);
            rd_done_d = rd_wrap;
        end
`ifdef FRAME_BUF_ALT_PINGPONG_EN
        // A freshly completed frame is always read from its first word
        if (wr_fire && wr_wrap) begin
            rd_addr_d = '0;
        end
`endif
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
        end
    end

    // RAM write port; enables are ignored while reset is held
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            mem[wr_mem_addr] <= data_in;
        end
    end

    // Registered RAM read port; sampling before the write lands gives read-before-write
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= mem[rd_mem_addr];
        end
    end

    assign data_out      = rd_data_q;
    assign wr_frame_done = wr_done_q;
    assign rd_frame_done = rd_done_q;

endmodule

// File: tb/tb_frame_buf_alt.sv
// tb/tb_frame_buf_alt.sv - scoreboard bench for frame_buf_alt (DEPTH=4 and DEPTH=8 instances)
module tb_frame_buf_alt;

    typedef struct {
        logic [31:0] d;
        logic        wf;
        logic        rf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en_in = 1'b1;
    logic        rd_en_in = 1'b1;
    logic [31:0] data_in = '0;

    logic [31:0] dout [2];
    logic        wfd  [2];
    logic        rfd  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance: 0 -> DEPTH 4, 1 -> DEPTH 8
    int          dep [2] = '{4, 8};
    logic [31:0] mm  [2][16];
    int          wa  [2];
    int          ra  [2];
    int          bank[2];
    logic [31:0] mdout[2];
    exp_t        sb0[$];
    exp_t        sb1[$];

    always #5 clk = ~clk;

    frame_buf_alt #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .rd_en_in(rd_en_in),
        .data_in(data_in), .data_out(dout[0]), .wr_frame_done(wfd[0]), .rd_frame_done(rfd[0])
    );

    frame_buf_alt #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .wr_en_in(wr_en_in), .rd_en_in(rd_en_in),
        .data_in(data_in), .data_out(dout[1]), .wr_frame_done(wfd[1]), .rd_frame_done(rfd[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model one clock edge of instance i, push what the DUT must show after it
    task automatic model(input int i, input logic r, input logic wn, input logic rn, input logic [31:0] d);
        exp_t e;
        int   ridx, widx;
        logic nwf, nrf;
        nwf = 1'b0;
        nrf = 1'b0;
        if (r) begin
            wa[i] = 0; ra[i] = 0; bank[i] = 0; mdout[i] = '0;
        end else begin
`ifdef FRAME_BUF_ALT_PINGPONG_EN
            ridx = ra[i] + (bank[i] == 0 ? dep[i] : 0);
            widx = wa[i] + (bank[i] == 1 ? dep[i] : 0);
`else
            ridx = ra[i];
            widx = wa[i];
`endif
            if (!rn) begin
                mdout[i] = mm[i][ridx];
                nrf = (ra[i] == dep[i] - 1);
                ra[i] = nrf ? 0 : ra[i] + 1;
            end
            if (!wn) begin
                mm[i][widx] = d;
                nwf = (wa[i] == dep[i] - 1);
                wa[i] = nwf ? 0 : wa[i] + 1;
`ifdef FRAME_BUF_ALT_PINGPONG_EN
                if (nwf) begin
                    bank[i] = 1 - bank[i];
                    ra[i] = 0;
                end
`endif
            end
        end
        e.d = mdout[i];
        e.wf = nwf;
        e.rf = nrf;
        if (i == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    task automatic step(input logic r, input logic wn, input logic rn, input logic [31:0] d);
        exp_t e;
        reset = r; wr_en_in = wn; rd_en_in = rn; data_in = d;
        for (int i = 0; i < 2; i++) model(i, r, wn, rn, d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
            // Locations never written hold undefined data; only flags are meaningful then
            if (!$isunknown(e.d)) chk($sformatf("data_out[%0d]", i), dout[i], e.d);
            chk($sformatf("wr_frame_done[%0d]", i), {31'b0, wfd[i]}, {31'b0, e.wf});
            chk($sformatf("rd_frame_done[%0d]", i), {31'b0, rfd[i]}, {31'b0, e.rf});
        end
    endtask

    initial begin
        logic [31:0] exp_wrap [4];
        exp_wrap = '{32'hA4, 32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) mm[i][k] = 'x;
        for (int i = 0; i < 2; i++) begin
            wa[i] = 0; ra[i] = 0; bank[i] = 0; mdout[i] = '0;
        end

        // Reset held two cycles with stray data and idle enables
        step(1'b1, 1'b1, 1'b1, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h1);
        chk("reset_dout", dout[0], 32'h0);
        chk("reset_wfd", {31'b0, wfd[0]}, 32'h0);

        // Sequential write then read (judged on the DEPTH=8 instance, no wrap)
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 32'(k + 2));
`ifndef FRAME_BUF_ALT_PINGPONG_EN
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("seq_read", dout[1], 32'(k + 2));
        end
        step(1'b0, 1'b1, 1'b1, 32'h0);
        chk("seq_hold", dout[1], 32'h6);
`else
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0);
`endif

        // Wrap and done flags on the DEPTH=4 instance
        step(1'b1, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(k));
            chk("wrap_wfd", {31'b0, wfd[0]}, (k == 3) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
`ifndef FRAME_BUF_ALT_PINGPONG_EN
            chk("wrap_read", dout[0], exp_wrap[k]);
`endif
            chk("wrap_rfd", {31'b0, rfd[0]}, (k == 3) ? 32'h1 : 32'h0);
        end

        // Same-address collision: read-before-write
        step(1'b1, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h11);
        step(1'b1, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h22);
`ifndef FRAME_BUF_ALT_PINGPONG_EN
        chk("collide_old", dout[0], 32'h11);
`endif
        step(1'b1, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
`ifndef FRAME_BUF_ALT_PINGPONG_EN
        chk("collide_new", dout[0], 32'h22);
`endif

        // Mid-stream reset during a read burst
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("midrst_dout", dout[0], 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Frame then concurrent read/write (bank isolation when ping-pong is built)
        step(1'b1, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 32'(k + 1));
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'(k + 5));
`ifdef FRAME_BUF_ALT_PINGPONG_EN
            chk("pingpong_read", dout[0], 32'(k + 1));
`endif
        end

        // Random traffic against the model
        for (int k = 0; k < 60; k++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
